mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency synchronous memory between two requesters:
//  - instruction fetch (IF, read-only)
//  - load/store datapath (LS), which supplies the word-aligned data and byte write mask.
//  Sequences each access: arbitrate, issue the command, count the latency, return data.
//  Rejects LS accesses flagged misaligned (wmask == 0) without touching memory.
// PARAMETERS
//  MEM_LATENCY   2   cycles from mem_en_o to valid mem_rdata_i; legal range >= 1
//  STARVE_MAX    4   consecutive LS grants allowed while if_req_i is pending
//  ADDR_W        30  word-address width driven to memory
// PORTS
//  clk           in   1       clock; all state updates on rising edge
//  rst           in   1       reset, asynchronous, active-high
//  if_req_i      in   1       fetch request; held with if_addr_i until if_gnt_o
//  if_addr_i     in   32      fetch byte address; bits [1:0] ignored
//  if_gnt_o      out  1       1-cycle pulse: fetch accepted this cycle
//  if_rvalid_o   out  1       1-cycle pulse: if_rdata_o valid
//  if_rdata_o    out  32      fetch data
//  ls_req_i      in   1       LS request; held with addr/we/wdata/wmask until ls_gnt_o
//  ls_we_i       in   1       1 = store, 0 = load
//  ls_addr_i     in   32      LS byte address; bits [1:0] ignored
//  ls_wdata_i    in   32      store data, already lane-shifted
//  ls_wmask_i    in   4       byte-lane mask; 4'b0000 = misaligned access
//  ls_gnt_o      out  1       1-cycle pulse: LS accepted this cycle
//  ls_rvalid_o   out  1       1-cycle pulse: load data or store ack
//  ls_rdata_o    out  32      raw memory word; 0 for stores and errors
//  ls_err_o      out  1       qualifies ls_rvalid_o: misaligned, no memory access made
//  mem_en_o      out  1       memory command strobe
//  mem_we_o      out  4       per-byte write enable; 0 on reads
//  mem_addr_o    out  ADDR_W  word address = winner addr[ADDR_W+1:2]
//  mem_wdata_o   out  32      write data
//  mem_rdata_i   in   32      read data, valid MEM_LATENCY cycles after mem_en_o
// BEHAVIOUR
//  - Reset: FSM = IDLE, latency counter = 0, starve counter = 0, owner = IF.
//    All outputs 0 while rst is high.
//  - FSM states:
//    IDLE: may grant.
//    BUSY: counting latency.
//    ERR: one-cycle LS error response.
//  - Grants are issued only in IDLE, or in the BUSY cycle that returns rvalid (back-to-back).
//  - A grant is combinational from the held request inputs.
//    mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o are driven in the grant cycle from the winner.
//  - Priority: LS beats IF, except when starve_cnt == STARVE_MAX and if_req_i is high; then IF wins.
//  - starve_cnt:
//    +1 on each LS grant while if_req_i is high (saturates at STARVE_MAX).
//    Cleared on any IF grant, or whenever if_req_i is low.
//  - Latency: grant at cycle T -> BUSY with cnt = 1.
//    cnt increments each cycle; at cnt == MEM_LATENCY the owner's rvalid pulses.
//    Owner rdata = mem_rdata_i in that cycle.
//    Then: IDLE, or BUSY with cnt = 1 if a new grant happens in the same cycle.
//  - Peak throughput: one access per MEM_LATENCY cycles.
//  - Stores complete identically: ls_rvalid_o at T+MEM_LATENCY, ls_rdata_o = 0.
//  - Misaligned LS (ls_req_i & ls_wmask_i == 0) that wins arbitration:
//    - ls_gnt_o pulses; mem_en_o stays 0.
//    - Next cycle (ERR): ls_rvalid_o = ls_err_o = 1, ls_rdata_o = 0.
//    - Then IDLE. No new grant is issued in the ERR cycle.
//  - Misaligned LS requests count as LS grants for starvation.
//  - Never more than one outstanding access; never both gnt outputs in one cycle.
//  - Inactive rdata outputs read 0.
//  - Requests dropped before their grant are legal; no grant is issued for them.
//  - Reset mid-access: the in-flight transaction is discarded and no rvalid is produced.
//    Requesters must re-request.
// STRUCTURE
//  - mem_arb_pkg contents:
//    - typedef enum {ST_IDLE, ST_BUSY, ST_ERR} arb_state_t;
//    - typedef enum {OWN_IF, OWN_LS} arb_owner_t;
//    - localparam WMASK_MISALIGNED = 4'b0000.
//  - Sub-module mem_arb_prio holds the winner-select logic and starve_cnt, and outputs grant_if/grant_ls.
//  - The top level holds the FSM, latency counter, owner register, and memory/response muxing.
// TESTING (MEM_LATENCY=2, STARVE_MAX=4; memory model returns a word-address-based pattern)
//  1. if_req, addr 0x100, mem word 0xDEADBEEF -> if_gnt @T, mem_en @T with addr 0x40, we 0;
//     if_rvalid @T+2, rdata 0xDEADBEEF.
//  2. if_req and ls_req (load 0x200) in the same cycle -> ls_gnt @T, ls_rvalid @T+2;
//     if_gnt @T+2 (back-to-back), if_rvalid @T+4.
//  3. Store addr 0x8, wmask 4'b0100, wdata 0x00AB0000 -> mem_we 4'b0100, mem_addr 0x2 @T;
//     ls_rvalid @T+2 with rdata 0 and err 0.
//  4. ls_req held high for 10 accesses, if_req pending -> exactly 4 LS grants, then 1 IF grant;
//     starve_cnt is then 0 and LS resumes.
//  5. ls_req, wmask 4'b0000 -> ls_gnt @T, mem_en 0; ls_rvalid = ls_err = 1 @T+1;
//     a pending if_req is granted @T+2.
//  6. rst pulsed @T+1 after a grant @T -> no rvalid at any time, all outputs 0 during reset;
//     a new if_req after release completes normally in 2 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, access owner, misaligned mask.
// Pure declarations, no logic or latency of its own.
// Imported by the arbiter top and the priority sub-block.
package mem_arb_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } arb_state_t;

  // Which requester owns the single outstanding access
  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_t;

  // LS byte mask value that flags a misaligned access
  localparam logic [3:0] WMASK_MISALIGNED = 4'b0000;

  // True when an LS mask marks the access as misaligned
  function automatic logic is_misaligned(input logic [3:0] wmask);
    return wmask == WMASK_MISALIGNED;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory command/data signals for the arbiter.
// No logic; carries signals only.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30
);

  // Instruction fetch port
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [31:0]       if_rdata_o;

  // Load/store port
  logic              ls_req_i;
  logic              ls_we_i;
  logic [31:0]       ls_addr_i;
  logic [31:0]       ls_wdata_i;
  logic [3:0]        ls_wmask_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [31:0]       ls_rdata_o;
  logic              ls_err_o;

  // Memory port
  logic              mem_en_o;
  logic [3:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    input  mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_wmask_i,
    output mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_arb_prio.sv
// Winner select between IF and LS with an LS-starvation guard for IF.
// Grants are combinational from the held requests, qualified by arb_en.
// Losing requester simply keeps its request held; no grant means no acceptance.
module mem_arb_prio #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic ls_req,
  output logic grant_if,
  output logic grant_ls
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  // Consecutive LS grants taken while a fetch was waiting
  logic [SW-1:0] starve_cnt;
  logic          if_starved;

  // LS normally wins; a fetch that has waited through STARVE_MAX LS grants goes first
  always_comb begin
    if_starved = if_req && (starve_cnt == STARVE_LIM);
    grant_ls   = arb_en && ls_req && !if_starved;
    grant_if   = arb_en && if_req && !grant_ls;
  end

  // Starvation counter: cleared when no fetch waits or a fetch is served, saturates otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_ls && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and load/store.
// Command issued in the grant cycle; response MEM_LATENCY cycles later (misaligned LS: 1 cycle).
// One access in flight; requesters hold their request until granted, grants back-to-back on return.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 4,
  parameter int ADDR_W      = 30
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LATENCY);

  arb_state_t    state, state_nxt;
  arb_owner_t    owner, owner_nxt;
  logic [CW-1:0] lat_cnt, lat_cnt_nxt;
  logic          ls_store, ls_store_nxt;

  logic          done;
  logic          arb_en;
  logic          grant_if;
  logic          grant_ls;
  logic          ls_misaligned;
  logic          ls_mem_access;
  logic          unused_addr_bits;

  // Byte-offset bits are not meaningful to a word-addressed memory
  assign unused_addr_bits = ^{bus.if_addr_i[1:0], bus.ls_addr_i[1:0]};

  // The in-flight access returns data in the cycle the counter reaches the latency
  assign done = (state == ST_BUSY) && (lat_cnt == LAT_LAST);

  // Grant window: idle, or the return cycle so accesses can run back-to-back.
  // Gated by rst so nothing is granted while reset is held.
  assign arb_en = !rst && ((state == ST_IDLE) || done);

  assign ls_misaligned = is_misaligned(bus.ls_wmask_i);
  assign ls_mem_access = grant_ls && !ls_misaligned;

  mem_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .if_req   (bus.if_req_i),
    .ls_req   (bus.ls_req_i),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  // FSM state, latency counter and owner registers; reset discards any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      owner    <= OWN_IF;
      ls_store <= 1'b0;
    end else begin
      state    <= state_nxt;
      lat_cnt  <= lat_cnt_nxt;
      owner    <= owner_nxt;
      ls_store <= ls_store_nxt;
    end
  end

  // Next-state: count latency in BUSY, leave ERR after one cycle, a new grant overrides
  always_comb begin
    state_nxt    = state;
    lat_cnt_nxt  = lat_cnt;
    owner_nxt    = owner;
    ls_store_nxt = ls_store;

    case (state)
      ST_IDLE: begin
        lat_cnt_nxt = '0;
      end
      ST_BUSY: begin
        if (done) begin
          state_nxt   = ST_IDLE;
          lat_cnt_nxt = '0;
        end else begin
          lat_cnt_nxt = lat_cnt + CW'(1);
        end
      end
      ST_ERR: begin
        state_nxt   = ST_IDLE;
        lat_cnt_nxt = '0;
      end
      default: begin
        state_nxt   = ST_IDLE;
        lat_cnt_nxt = '0;
      end
    endcase

    // A misaligned LS grant skips memory and answers from ERR next cycle
    if (grant_ls && ls_misaligned) begin
      state_nxt    = ST_ERR;
      lat_cnt_nxt  = '0;
      owner_nxt    = OWN_LS;
      ls_store_nxt = 1'b0;
    end else if (grant_ls) begin
      state_nxt    = ST_BUSY;
      lat_cnt_nxt  = CW'(1);
      owner_nxt    = OWN_LS;
      ls_store_nxt = bus.ls_we_i;
    end else if (grant_if) begin
      state_nxt    = ST_BUSY;
      lat_cnt_nxt  = CW'(1);
      owner_nxt    = OWN_IF;
      ls_store_nxt = 1'b0;
    end
  end

  // Grant pulses and memory command, driven from the winner in the grant cycle
  always_comb begin
    bus.if_gnt_o    = grant_if;
    bus.ls_gnt_o    = grant_ls;
    bus.mem_en_o    = grant_if || ls_mem_access;
    bus.mem_we_o    = 4'b0000;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (ls_mem_access) begin
      bus.mem_addr_o = bus.ls_addr_i[ADDR_W+1:2];
      if (bus.ls_we_i) begin
        bus.mem_we_o    = bus.ls_wmask_i;
        bus.mem_wdata_o = bus.ls_wdata_i;
      end
    end else if (grant_if) begin
      bus.mem_addr_o = bus.if_addr_i[ADDR_W+1:2];
    end
  end

  // Response pulses to the owner; rdata is zero unless it carries load/fetch data
  always_comb begin
    bus.if_rvalid_o = done && (owner == OWN_IF);
    bus.ls_rvalid_o = (done && (owner == OWN_LS)) || (state == ST_ERR);
    bus.ls_err_o    = (state == ST_ERR);
    bus.if_rdata_o  = '0;
    bus.ls_rdata_o  = '0;
    if (done && (owner == OWN_IF)) begin
      bus.if_rdata_o = bus.mem_rdata_i;
    end
    if (done && (owner == OWN_LS) && !ls_store) begin
      bus.ls_rdata_o = bus.mem_rdata_i;
    end
  end

endmodule
